pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic inter-stage pipeline register for the MIPS pipeline (D->E, E->M, M->W).
- Replaces fixed-width, always-advancing stage registers with a valid/ready handshake and a 2-entry skid buffer (output register + skid register).
- Keeps the existing kill semantics: flush inserts a nop bubble that carries the incoming PC/BD; req inserts a bubble at the exception vector.
- Payload: instr, pc, generic data bus, bd, exc code, check bit.

Parameters:
- DATA_W, 96, width of the generic payload bus (e.g. WD1, WD2, EXTResult concatenated).
- EXC_W, 5, exception-code width.
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC value loaded on req.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  kill stage; insert bubble carrying in_pc/in_bd
- req  in  1  exception/interrupt request; insert bubble at EXC_VECTOR
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_instr  in  32  instruction
- in_pc  in  32  PC
- in_data  in  DATA_W  payload
- in_bd  in  1  branch-delay flag
- in_exc  in  EXC_W  exception code
- in_check  in  1  check flag
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_instr, out_pc, out_data, out_bd, out_exc, out_check  out  (widths as inputs)  registered entry

Behaviour:
- Priority each cycle: reset > req > flush > normal.
- Acceptance and output transfer:
  - acc = in_valid & in_ready.
  - xfer = out_valid & out_ready.
  - in_ready = !skid_valid & !flush & !req & !reset (combinational).
- Reset (posedge clk):
  - out_valid 0, out_instr 0, out_pc PC_RESET, out_data 0, out_bd 0, out_exc 0, out_check 0.
  - skid cleared (skid_valid 0, contents 0).
  - in_ready 1 on the first cycle after reset.
- req:
  - Skid cleared; nothing accepted that cycle.
  - Output register loaded with bubble: instr 0, pc EXC_VECTOR, data 0, bd 0, exc 0, check 0, out_valid 1.
  - The loaded entry is overwritten regardless of out_ready.
- flush (without req):
  - Skid cleared; input not consumed (upstream holds).
  - Output loaded with bubble: instr 0, pc in_pc, bd in_bd, data/exc/check 0, out_valid 1.
  - The loaded entry is overwritten regardless of out_ready.
- Normal operation; output "free" = !out_valid | out_ready:
  - free & skid_valid: output <- skid; skid <- in if acc, else skid_valid 0.
  - free & !skid_valid & acc: output <- in, out_valid 1.
  - free & !skid_valid & !acc: out_valid 0, payload held.
  - !free & acc: skid <- in, skid_valid 1 (only possible when skid empty).
  - !free & !acc: hold everything.
- Latency: 1 cycle in->out when unstalled. Full throughput: 1 entry/cycle.
- Ordering strictly preserved; no entry dropped or duplicated except by flush/req.
- Full condition: skid_valid=1 -> in_ready=0. in_ready returns to 1 the cycle after the stall drains one entry.
- Reset asserted while an entry is buffered discards all entries.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and bubble_cnt[31:0]:
  - stall_cnt increments on out_valid & !out_ready.
  - bubble_cnt increments on any cycle with flush|req (not reset).
  - Both clear on reset and wrap at 2^32.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - PC_RESET_DEF, EXC_VECTOR_DEF, EXC_W_DEF.
  - Packed struct type for the stage entry (instr, pc, data, bd, exc, check).
  - Function make_bubble(pc, bd).
- Sub-module pipe_entry_reg: one entry register with load/clear/bubble controls and a valid bit, instantiated twice (output and skid).

Test Plan:
- Reset, then in_valid=1 with pc=0x3004, out_ready=1 -> out_pc=0x3004 one cycle later, out_valid=1. Before that: out_pc=0x3000, out_valid=0.
- Stream pc 0x3000,0x3004,0x3008; hold out_ready=0 after the first -> skid fills, in_ready=0. Release out_ready -> outputs 0x3000,0x3004,0x3008 in order, no loss.
- flush with in_pc=0x3010, in_bd=1 while out stalled -> out_instr=0, out_pc=0x3010, out_bd=1, skid empty, in_ready=0 that cycle.
- req and flush in the same cycle with a full skid -> out_pc=0x4180, out_bd=0, out_exc=0, skid empty.
- reset asserted while out_valid=1 and skid full -> next cycle out_pc=0x3000, out_valid=0, in_ready=1.
- With PIPE_PERF_CNT_EN: 3 stalled cycles plus 2 flush cycles -> stall_cnt=3, bubble_cnt=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults, default-width stage entry type and bubble builder for the MIPS stage registers.
package pipe_pkg;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam int EXC_W_DEF = 5;
  localparam int DATA_W_DEF = 96;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [DATA_W_DEF-1:0] data;
    logic bd;
    logic [EXC_W_DEF-1:0] exc;
    logic check;
  } entry_t;
  function automatic entry_t make_bubble(input logic [31:0] pc, input logic bd);
    entry_t e;
    e = '0;
    e.pc = pc;
    e.bd = bd;
    return e;
  endfunction
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one stage entry with valid bit; priority reset > clear > bubble > load > drop.
module pipe_entry_reg #(
  parameter int W = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         bubble,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] bub,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST;
      valid <= 1'b0;
    end else if (clear) begin
      q <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      q <= bub;
      valid <= 1'b1;
    end else if (load) begin
      q <= d;
      valid <= 1'b1;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: elastic pipeline stage register (output + skid entry) with flush/req bubbles.
// Define PIPE_PERF_CNT_EN to add stall_cnt/bubble_cnt performance counters.
module pipe_stage_skid_reg import pipe_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXC_W = EXC_W_DEF,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_check,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_check
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [DATA_W-1:0] data;
    logic bd;
    logic [EXC_W-1:0] exc;
    logic check;
  } stage_t;
  localparam int W = $bits(stage_t);
  localparam stage_t RST_E = '{instr: '0, pc: PC_RESET, data: '0, bd: 1'b0, exc: '0, check: 1'b0};
  stage_t in_e, bub_e, o_e, s_e;
  logic o_valid, s_valid, acc, free;
  assign in_ready = !s_valid & !flush & !req & !reset;
  assign acc = in_valid & in_ready;
  assign free = !o_valid | out_ready;
  assign in_e = '{instr: in_instr, pc: in_pc, data: in_data, bd: in_bd, exc: in_exc, check: in_check};
  assign bub_e = '{instr: '0, pc: req ? EXC_VECTOR : in_pc, data: '0, bd: !req & in_bd, exc: '0, check: 1'b0};
  pipe_entry_reg #(.W(W), .RST(RST_E)) u_out (
    .clk(clk), .reset(reset), .clear(1'b0), .bubble(req | flush),
    .load(free & (s_valid | acc)), .drop(free), .bub(bub_e),
    .d(s_valid ? s_e : in_e), .q(o_e), .valid(o_valid)
  );
  // The skid only ever fills while the output is stalled, so it drains before new input is taken.
  pipe_entry_reg #(.W(W), .RST('0)) u_skid (
    .clk(clk), .reset(reset), .clear(req | flush), .bubble(1'b0),
    .load(!free & acc), .drop(free), .bub('0),
    .d(in_e), .q(s_e), .valid(s_valid)
  );
  assign out_valid = o_valid;
  assign out_instr = o_e.instr;
  assign out_pc = o_e.pc;
  assign out_data = o_e.data;
  assign out_bd = o_e.bd;
  assign out_exc = o_e.exc;
  assign out_check = o_e.check;
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (o_valid & !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush | req) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed self-checking bench for the elastic stage register.
module tb_pipe_stage_skid_reg;
  logic clk = 0, reset = 1, flush = 0, req = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0, out_instr, out_pc;
  logic [95:0] in_data = 0, out_data;
  logic in_bd = 0, in_check = 0, out_bd, out_check;
  logic [4:0] in_exc = 0, out_exc;
  int pass = 0, total = 0;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  pipe_stage_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .req(req),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_data(in_data), .in_bd(in_bd), .in_exc(in_exc), .in_check(in_check),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_data(out_data), .out_bd(out_bd), .out_exc(out_exc), .out_check(out_check)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc = pc;
    in_instr = pc ^ 32'hA5A5_0000;
    #1;
  endtask
  task automatic fill_skid(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1; put(1, a); step();
    out_ready = 0; put(1, b); step();
    put(0, 0);
  endtask
  task automatic test_reset();
    reset = 1; step(); step(); reset = 0; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else pass++;
    total++; if (out_pc !== 32'h3000) $display("FAIL rst_pc got %h want 00003000", out_pc); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else pass++;
    total++; if (out_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", out_instr); else pass++;
  endtask
  task automatic test_pass();
    out_ready = 1; put(1, 32'h3004); step();
    total++; if (out_pc !== 32'h3004) $display("FAIL pass_pc got %h want 00003004", out_pc); else pass++;
    total++; if (out_valid !== 1'b1) $display("FAIL pass_valid got %b want 1", out_valid); else pass++;
    total++; if (out_instr !== 32'hA5A5_3004) $display("FAIL pass_instr got %h want a5a53004", out_instr); else pass++;
  endtask
  task automatic test_skid();
    out_ready = 1; put(1, 32'h3000); step();
    total++; if (out_pc !== 32'h3000) $display("FAIL skid_first got %h want 00003000", out_pc); else pass++;
    out_ready = 0; put(1, 32'h3004); step();
    put(1, 32'h3008);
    total++; if (in_ready !== 1'b0) $display("FAIL skid_full_ready got %b want 0", in_ready); else pass++;
    step();
    total++; if (out_pc !== 32'h3000) $display("FAIL skid_hold got %h want 00003000", out_pc); else pass++;
    out_ready = 1; #1; step();
    total++; if (out_pc !== 32'h3004) $display("FAIL skid_second got %h want 00003004", out_pc); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL skid_drain_ready got %b want 1", in_ready); else pass++;
    step();
    total++; if (out_pc !== 32'h3008 || out_valid !== 1'b1) $display("FAIL skid_third got %h/%b want 00003008/1", out_pc, out_valid); else pass++;
    put(0, 0); step();
    total++; if (out_valid !== 1'b0) $display("FAIL skid_empty got %b want 0", out_valid); else pass++;
  endtask
  task automatic test_flush();
    fill_skid(32'h3020, 32'h3024);
    flush = 1; in_valid = 1; in_pc = 32'h3010; in_bd = 1; in_instr = 32'h1234; in_exc = 5'h3; in_check = 1; in_data = 96'hFF; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", in_ready); else pass++;
    step(); flush = 0; #1;
    total++; if (out_instr !== 32'h0 || out_pc !== 32'h3010 || out_bd !== 1'b1) $display("FAIL flush_bubble got %h/%h/%b want 0/00003010/1", out_instr, out_pc, out_bd); else pass++;
    total++; if (out_data !== 96'h0 || out_exc !== 5'h0 || out_check !== 1'b0 || out_valid !== 1'b1) $display("FAIL flush_fields got %h/%h/%b/%b want 0/0/0/1", out_data, out_exc, out_check, out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_skid_cleared got %b want 1", in_ready); else pass++;
    in_bd = 0; in_exc = 0; in_check = 0; in_data = 0; put(0, 0); out_ready = 1; step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_no_leftover got %b want 0", out_valid); else pass++;
  endtask
  task automatic test_req();
    fill_skid(32'h3030, 32'h3034);
    req = 1; flush = 1; in_valid = 1; in_pc = 32'h3040; in_bd = 1; in_exc = 5'h5; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL req_ready got %b want 0", in_ready); else pass++;
    step(); req = 0; flush = 0; in_bd = 0; in_exc = 0; #1;
    total++; if (out_pc !== 32'h4180 || out_bd !== 1'b0 || out_exc !== 5'h0) $display("FAIL req_bubble got %h/%b/%h want 00004180/0/0", out_pc, out_bd, out_exc); else pass++;
    total++; if (out_valid !== 1'b1 || out_instr !== 32'h0) $display("FAIL req_valid got %b/%h want 1/0", out_valid, out_instr); else pass++;
    put(0, 0); out_ready = 1; step();
    total++; if (out_valid !== 1'b0) $display("FAIL req_skid_cleared got %b want 0", out_valid); else pass++;
  endtask
  task automatic test_reset_full();
    fill_skid(32'h3050, 32'h3054);
    reset = 1; step(); reset = 0; #1;
    total++; if (out_pc !== 32'h3000 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstfull got %h/%b/%b want 00003000/0/1", out_pc, out_valid, in_ready); else pass++;
    out_ready = 1; step();
    total++; if (out_valid !== 1'b0) $display("FAIL rstfull_discard got %b want 0", out_valid); else pass++;
  endtask
  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 96'(i + 7); put(1, 32'h3100 + 32'(4 * i));
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); else pass++;
      step();
      total++; if (out_pc !== 32'h3100 + 32'(4 * i) || out_data !== 96'(i + 7) || out_valid !== 1'b1) $display("FAIL b2b_out[%0d] got %h/%h/%b want %h/%h/1", i, out_pc, out_data, out_valid, 32'h3100 + 32'(4 * i), 96'(i + 7)); else pass++;
    end
    in_data = 0; put(0, 0); step();
  endtask
`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    reset = 1; step(); reset = 0; #1;
    total++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) $display("FAIL perf_rst got %0d/%0d want 0/0", stall_cnt, bubble_cnt); else pass++;
    out_ready = 1; put(1, 32'h3200); step();
    out_ready = 0; put(0, 0); step(); step(); step();
    out_ready = 1; flush = 1; #1; step(); step(); flush = 0; #1;
    total++; if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd2) $display("FAIL perf_cnt got %0d/%0d want 3/2", stall_cnt, bubble_cnt); else pass++;
  endtask
`endif
  initial begin
    test_reset();
    test_pass();
    test_skid();
    test_flush();
    test_req();
    test_reset_full();
    test_back_to_back();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
